// File: rtl/merge32_stream_out_pkg.sv
// Shared types for the merge32 output streamer.
// Holds the FSM state encoding and default geometry of the merge network.
package merge32_stream_out_pkg;

  // Default geometry: 2n = 32 keys of 3 bits each.
  localparam int unsigned WIDTH_DEF = 3;
  localparam int unsigned N_DEF     = 16;
  localparam int unsigned IDXW_DEF  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/merge_snapshot_mux.sv
// Snapshot register for one merged frame plus the element read mux.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (clears the snapshot)
//   cap_en      - capture c_in into the snapshot this cycle
//   c_in        - merged frame, element i at [(i+1)*WIDTH-1 : i*WIDTH]
//   rd_idx      - element position to read
//   rd_data_c   - combinational read of snapshot[rd_idx]
module merge_snapshot_mux #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned N2    = 32,
  parameter int unsigned IDXW  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cap_en,
  input  logic [N2*WIDTH-1:0]   c_in,
  input  logic [IDXW-1:0]       rd_idx,
  output logic [WIDTH-1:0]      rd_data_c
);

  logic [WIDTH-1:0] snap [N2];

  // Frame capture register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N2); i++) snap[i] <= '0;
    end else if (cap_en) begin
      for (int i = 0; i < int'(N2); i++) snap[i] <= c_in[i*WIDTH +: WIDTH];
    end
  end

  assign rd_data_c = snap[rd_idx];

endmodule

// File: rtl/merge32_stream_out.sv
// Streams the first K elements of a snapshotted 2n-element merge result over
// valid/ready, ascending or descending, and flags non-monotonic output.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset
//   start       - one-cycle pulse, c_in holds a merged frame
//   c_in        - merged frame, element 0 smallest
//   out_data    - current element          out_index - its snapshot position
//   out_valid   - output element valid     out_ready - sink accepts element
//   out_last    - current element is the K-th of the frame
//   busy        - frame in progress        done      - pulse after last accept
//   overrun     - sticky, start seen while streaming (cleared by reset only)
//   sort_err    - sticky per frame, monotonic check failed
module merge32_stream_out
  import merge32_stream_out_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned N     = N_DEF,
  parameter int unsigned K     = 2 * N_DEF,
  parameter int unsigned DESC  = 0,
  parameter int unsigned IDXW  = IDXW_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2*N*WIDTH-1:0]   c_in,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDXW-1:0]        out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun,
  output logic                   sort_err
);

  localparam int unsigned N2        = 2 * N;
  localparam int unsigned CW        = IDXW + 1;
  localparam int unsigned FIRST_IDX = (DESC != 0) ? N2 - 1 : 0;
  localparam int unsigned FIRST_LSB = FIRST_IDX * WIDTH;
  localparam logic [IDXW-1:0] FIRST_POS = IDXW'(FIRST_IDX);
  localparam logic [CW-1:0]   LAST_CNT  = CW'(K - 1);

  state_e           state, state_d;
  logic [CW-1:0]    count, count_d;
  logic [WIDTH-1:0] prev, prev_d;
  logic [WIDTH-1:0] out_data_d;
  logic [IDXW-1:0]  out_index_d;
  logic             out_valid_d, out_last_d, busy_d, done_d, overrun_d, sort_err_d;

  logic             cap_en;
  logic             accept;
  logic             order_bad;
  logic [IDXW-1:0]  next_pos;
  logic [WIDTH-1:0] next_data_c;
  logic [WIDTH-1:0] first_data;

  assign cap_en   = start && (state != ST_STREAM);
  assign accept   = out_valid && out_ready;
  // Position of the element after the one currently presented.
  assign next_pos = (DESC != 0) ? IDXW'(N2 - 2) - count[IDXW-1:0]
                                : count[IDXW-1:0] + IDXW'(1);
  // The first element comes straight from c_in since the snapshot loads in parallel.
  assign first_data = c_in[FIRST_LSB +: WIDTH];
  // First element of a frame has no predecessor to compare against.
  assign order_bad = (count != '0) &&
                     ((DESC != 0) ? (out_data > prev) : (out_data < prev));

  merge_snapshot_mux #(
    .WIDTH (WIDTH),
    .N2    (N2),
    .IDXW  (IDXW)
  ) u_snap (
    .clk       (clk),
    .rst_n     (rst),
    .cap_en    (cap_en),
    .c_in      (c_in),
    .rd_idx    (next_pos),
    .rd_data_c (next_data_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    count_d     = count;
    prev_d      = prev;
    out_data_d  = out_data;
    out_index_d = out_index;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    busy_d      = busy;
    done_d      = 1'b0;
    overrun_d   = overrun;
    sort_err_d  = sort_err;

    unique case (state)
      ST_STREAM: begin
        if (start) overrun_d = 1'b1;
        if (accept) begin
          prev_d = out_data;
          if (order_bad) sort_err_d = 1'b1;
          if (out_last) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end else begin
            count_d     = count + CW'(1);
            out_index_d = next_pos;
            out_data_d  = next_data_c;
            out_last_d  = ((count + CW'(1)) == LAST_CNT);
          end
        end
      end
      default: begin
        // IDLE and DONE both accept a new frame.
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
        if (start) begin
          state_d     = ST_STREAM;
          count_d     = '0;
          sort_err_d  = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          out_index_d = FIRST_POS;
          out_data_d  = first_data;
          out_last_d  = (LAST_CNT == '0);
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      prev      <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      sort_err  <= 1'b0;
    end else begin
      state     <= state_d;
      count     <= count_d;
      prev      <= prev_d;
      out_data  <= out_data_d;
      out_index <= out_index_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
      done      <= done_d;
      overrun   <= overrun_d;
      sort_err  <= sort_err_d;
    end
  end

endmodule

// File: tb/tb_merge32_stream_out.sv
// Scoreboard bench for merge32_stream_out: an ascending K=32 instance and a
// descending K=4 instance share c_in, out_ready and reset.
module tb_merge32_stream_out;

  localparam int W  = 3;
  localparam int N2 = 32;
  localparam int KD = 4;

  typedef logic [W-1:0] frame_t [N2];
  typedef struct packed {
    logic [W-1:0] d;
    logic [4:0]   i;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start_a, start_d, out_ready;
  logic [N2*W-1:0] c_in;

  logic [W-1:0] a_data, d_data;
  logic [4:0]   a_index, d_index;
  logic a_valid, a_last, a_busy, a_done, a_overrun, a_sort_err;
  logic d_valid, d_last, d_busy, d_done, d_overrun, d_sort_err;

  always #5 clk = ~clk;

  merge32_stream_out dut_a (
    .clk(clk), .rst(rst), .start(start_a), .c_in(c_in),
    .out_data(a_data), .out_index(a_index), .out_valid(a_valid),
    .out_ready(out_ready), .out_last(a_last), .busy(a_busy), .done(a_done),
    .overrun(a_overrun), .sort_err(a_sort_err)
  );

  merge32_stream_out #(.DESC(1), .K(KD)) dut_d (
    .clk(clk), .rst(rst), .start(start_d), .c_in(c_in),
    .out_data(d_data), .out_index(d_index), .out_valid(d_valid),
    .out_ready(out_ready), .out_last(d_last), .busy(d_busy), .done(d_done),
    .overrun(d_overrun), .sort_err(d_sort_err)
  );

  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qd[$];
  int   acc_a = 0;
  int   acc_d = 0;
  bit   exp_err = 1'b0;
  bit   have_prev = 1'b0;
  logic [W-1:0] prev_m = '0;
  int   rmode = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [N2*W-1:0] pack(input frame_t f);
    logic [N2*W-1:0] r;
    for (int i = 0; i < N2; i++) r[i*W +: W] = f[i];
    return r;
  endfunction

  function automatic frame_t ramp();
    frame_t f;
    for (int i = 0; i < N2; i++) f[i] = W'(i / 4);
    return f;
  endfunction

  function automatic frame_t rand_sorted();
    frame_t f;
    int q[$];
    for (int i = 0; i < N2; i++) q.push_back(int'($urandom_range(0, 7)));
    q.sort();
    for (int i = 0; i < N2; i++) f[i] = W'(q[i]);
    return f;
  endfunction

  function automatic logic [N2*W-1:0] rnd_bus();
    return 96'({$urandom, $urandom, $urandom});
  endfunction

  // Expected emission: first k positions in the chosen order.
  task automatic push_frame(input frame_t f, input bit desc, input int k);
    exp_t e;
    int p;
    for (int j = 0; j < k; j++) begin
      p   = desc ? N2 - 1 - j : j;
      e.d = f[p];
      e.i = 5'(p);
      e.l = (j == k - 1);
      if (desc) qd.push_back(e); else qa.push_back(e);
    end
  endtask

  // Ready pattern: 0 = always, 1 = toggle, 2 = random (75% ready).
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (rmode)
        1:       out_ready = cyc[0];
        2:       out_ready = ($urandom % 4) != 0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor for the ascending instance.
  bit   hold_a = 1'b0;
  exp_t held_a;
  always @(negedge clk) begin
    exp_t cur, e;
    cur.d = a_data; cur.i = a_index; cur.l = a_last;
    if (!rst) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) chk("hold_a", 32'(cur), 32'(held_a));
      chk("sort_err_a", 32'(a_sort_err), 32'(exp_err));
      if (a_valid && out_ready) begin
        if (qa.size() == 0) begin
          chk("unexpected_elem_a", 32'(cur), 32'(0) - 32'(1));
        end else begin
          e = qa.pop_front();
          chk("elem_a", 32'(cur), 32'(e));
          if (have_prev && e.d < prev_m) exp_err = 1'b1;
          prev_m = e.d;
          have_prev = 1'b1;
        end
        acc_a++;
      end
      hold_a = a_valid && !out_ready;
      held_a = cur;
    end
  end

  // Monitor for the descending instance.
  bit   hold_d = 1'b0;
  exp_t held_d;
  always @(negedge clk) begin
    exp_t cur, e;
    cur.d = d_data; cur.i = d_index; cur.l = d_last;
    if (!rst) begin
      hold_d = 1'b0;
    end else begin
      if (hold_d) chk("hold_d", 32'(cur), 32'(held_d));
      if (d_valid && out_ready) begin
        if (qd.size() == 0) begin
          chk("unexpected_elem_d", 32'(cur), 32'(0) - 32'(1));
        end else begin
          e = qd.pop_front();
          chk("elem_d", 32'(cur), 32'(e));
        end
        acc_d++;
      end
      hold_d = d_valid && !out_ready;
      held_d = cur;
    end
  end

  // Issue a frame; now=1 drives start immediately (used from the DONE cycle).
  task automatic issue(input frame_t f, input bit to_d, input bit now);
    if (!now) begin
      @(posedge clk);
      #1;
    end
    c_in = pack(f);
    if (to_d) start_d = 1'b1; else start_a = 1'b1;
    push_frame(f, to_d, to_d ? KD : N2);
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_d = 1'b0;
    c_in = rnd_bus();
    if (to_d) begin
      acc_d = 0;
    end else begin
      exp_err = 1'b0;
      have_prev = 1'b0;
      acc_a = 0;
    end
  endtask

  // Wait for done; n counts cycles from the first cycle after the start edge.
  task automatic wait_done(input bit to_d, output int n);
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      seen = to_d ? d_done : a_done;
    end
    chk("done_seen", 32'(seen), 32'(1));
    chk("drained", to_d ? 32'(qd.size()) : 32'(qa.size()), 32'(0));
  endtask

  task automatic wait_acc(input int target);
    int k;
    k = 0;
    while (acc_a < target && k < 200) begin
      @(posedge clk);
      k++;
    end
    chk("reach_elem", 32'(acc_a >= target), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    int n;
    rst = 1'b0; start_a = 1'b0; start_d = 1'b0; c_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", 32'({a_data, a_index, a_valid, a_last, a_busy, a_done, a_overrun, a_sort_err}), 32'(0));
    chk("reset_d", 32'({d_data, d_index, d_valid, d_last, d_busy, d_done, d_overrun, d_sort_err}), 32'(0));
    rst = 1'b1;

    // Ascending ramp at full rate.
    rmode = 0;
    issue(ramp(), 1'b0, 1'b0);
    chk("busy_a", 32'(a_busy), 32'(1));
    wait_done(1'b0, n);
    chk("done_cycle", 32'(n), 32'(33));
    chk("sort_err_ramp", 32'(a_sort_err), 32'(0));
    @(negedge clk);
    chk("done_one_cycle", 32'({a_done, a_busy, a_valid}), 32'(0));

    // Alternating backpressure.
    rmode = 1;
    issue(ramp(), 1'b0, 1'b0);
    wait_done(1'b0, n);
    chk("bp_done_cycle", 32'((n == 64) || (n == 65)), 32'(1));
    rmode = 0;

    // Descending K=4.
    issue(ramp(), 1'b1, 1'b0);
    wait_done(1'b1, n);
    chk("desc_done_cycle", 32'(n), 32'(5));
    chk("sort_err_desc", 32'(d_sort_err), 32'(0));

    // Unsorted frame, then a sorted frame that clears sort_err.
    f = ramp();
    f[5] = 3'd7;
    f[6] = 3'd0;
    issue(f, 1'b0, 1'b0);
    wait_done(1'b0, n);
    chk("sort_err_set", 32'(a_sort_err), 32'(1));

    rmode = 2;
    for (int r = 0; r < 4; r++) begin
      issue(rand_sorted(), 1'b0, 1'b0);
      wait_done(1'b0, n);
    end
    for (int r = 0; r < 3; r++) begin
      issue(rand_sorted(), 1'b1, 1'b0);
      wait_done(1'b1, n);
      chk("sort_err_desc_rand", 32'(d_sort_err), 32'(0));
    end
    rmode = 0;

    // start during streaming, then start in the DONE cycle.
    issue(ramp(), 1'b0, 1'b0);
    wait_acc(10);
    #1;
    start_a = 1'b1;
    c_in = rnd_bus();
    @(posedge clk);
    #1;
    start_a = 1'b0;
    chk("overrun_set", 32'(a_overrun), 32'(1));
    wait_done(1'b0, n);
    issue(rand_sorted(), 1'b0, 1'b1);
    @(negedge clk);
    chk("valid_after_done_start", 32'(a_valid), 32'(1));
    wait_done(1'b0, n);
    chk("overrun_sticky", 32'(a_overrun), 32'(1));

    // Asynchronous reset mid-frame.
    issue(ramp(), 1'b0, 1'b0);
    wait_acc(15);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_a", 32'({a_data, a_index, a_valid, a_last, a_busy, a_done, a_overrun, a_sort_err}), 32'(0));
    qa.delete();
    exp_err = 1'b0;
    have_prev = 1'b0;
    acc_a = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_after_reset", 32'({a_done, a_valid, a_busy}), 32'(0));
    end
    issue(rand_sorted(), 1'b0, 1'b0);
    wait_done(1'b0, n);
    chk("overrun_cleared", 32'(a_overrun), 32'(0));

    repeat (3) @(negedge clk);
    chk("final_qd_empty", 32'(qd.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
